// File: rtl/ray_request_scheduler.sv
// ray_request_scheduler: round-robin sharing of one calcRay datapath between N_REQ requesters,
// with a {valid,id} tag pipeline and square/r alignment into one tagged result register.
module ray_request_scheduler #(
    parameter int N_REQ       = 4,
    parameter int ID_W        = 2,
    parameter int IN_W        = 8,
    parameter int OUT_W       = 8,
    parameter int SQ_LATENCY  = 1,
    parameter int RAY_LATENCY = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    flush,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*IN_W-1:0]   req_x,
    input  logic [N_REQ*IN_W-1:0]   req_y,
    input  logic [N_REQ*IN_W-1:0]   req_z,
    output logic [IN_W-1:0]         ray_x,
    output logic [IN_W-1:0]         ray_y,
    output logic [IN_W-1:0]         ray_z,
    input  logic [OUT_W-1:0]        ray_xsq,
    input  logic [OUT_W-1:0]        ray_ysq,
    input  logic [OUT_W-1:0]        ray_zsq,
    input  logic [OUT_W-1:0]        ray_r,
    output logic                    res_valid,
    output logic [ID_W-1:0]         res_id,
    output logic [OUT_W-1:0]        res_xsq,
    output logic [OUT_W-1:0]        res_ysq,
    output logic [OUT_W-1:0]        res_zsq,
    output logic [OUT_W-1:0]        res_r,
    output logic                    busy,
    output logic [15:0]             issue_cnt
);
    localparam int D = RAY_LATENCY - SQ_LATENCY;

    logic [ID_W-1:0]        ptr_q, ptr_d, sel;
    logic [IN_W-1:0]        x_q, y_q, z_q, x_d, y_d, z_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [RAY_LATENCY:0]   tv_q, tv_d;
    logic [ID_W-1:0]        tid_q [RAY_LATENCY+1];
    logic [ID_W-1:0]        tid_d [RAY_LATENCY+1];
    logic                   rv_q, rv_d;
    logic [ID_W-1:0]        rid_q, rid_d;
    logic [3*OUT_W-1:0]     rsq_q, rsq_d, sq_al;
    logic [OUT_W-1:0]       r_q, r_d;
    logic [2*N_REQ-1:0]     rot;
    logic                   found, hs;
    int                     s;

    // rot[o] is requester (ptr+o) mod N_REQ; scanning o downward leaves the nearest one
    always_comb begin
        rot   = {req_valid, req_valid} >> ptr_q;
        found = 1'b0;
        sel   = '0;
        s     = 0;
        for (int o = N_REQ - 1; o >= 0; o--) begin
            if (rot[o]) begin
                found = 1'b1;
                s     = int'(ptr_q) + o;
                if (s >= N_REQ) s = s - N_REQ;
                sel   = ID_W'(s);
            end
        end
        hs        = found & enable & ~flush & reset;
        req_ready = hs ? (N_REQ'(1) << sel) : '0;
    end

    always_comb begin
        x_d    = hs ? req_x[sel*IN_W +: IN_W] : x_q;
        y_d    = hs ? req_y[sel*IN_W +: IN_W] : y_q;
        z_d    = hs ? req_z[sel*IN_W +: IN_W] : z_q;
        ptr_d  = hs ? ((int'(sel) == N_REQ - 1) ? '0 : sel + 1'b1) : ptr_q;
        cnt_d  = cnt_q + 16'(hs);
        tv_d   = flush ? '0 : {tv_q[RAY_LATENCY-1:0], hs};
        tid_d[0] = hs ? sel : tid_q[0];
        for (int j = 1; j <= RAY_LATENCY; j++) tid_d[j] = tid_q[j-1];
        rv_d   = tv_q[RAY_LATENCY] & ~flush;
        rid_d  = rv_d ? tid_q[RAY_LATENCY] : rid_q;
        rsq_d  = rv_d ? sq_al : rsq_q;
        r_d    = rv_d ? ray_r : r_q;
    end

    generate
        if (D == 0) begin : g_direct
            assign sq_al = {ray_xsq, ray_ysq, ray_zsq};
        end else begin : g_delay
            logic [3*OUT_W-1:0] dl_q [D];
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    dl_q <= '{default: '0};
                end else begin
                    dl_q[0] <= {ray_xsq, ray_ysq, ray_zsq};
                    for (int j = 1; j < D; j++) dl_q[j] <= dl_q[j-1];
                end
            end
            assign sq_al = dl_q[D-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
            z_q   <= '0;
            cnt_q <= '0;
            tv_q  <= '0;
            tid_q <= '{default: '0};
            rv_q  <= 1'b0;
            rid_q <= '0;
            rsq_q <= '0;
            r_q   <= '0;
        end else begin
            ptr_q <= ptr_d;
            x_q   <= x_d;
            y_q   <= y_d;
            z_q   <= z_d;
            cnt_q <= cnt_d;
            tv_q  <= tv_d;
            tid_q <= tid_d;
            rv_q  <= rv_d;
            rid_q <= rid_d;
            rsq_q <= rsq_d;
            r_q   <= r_d;
        end
    end

    assign ray_x     = x_q;
    assign ray_y     = y_q;
    assign ray_z     = z_q;
    assign res_valid = rv_q;
    assign res_id    = rid_q;
    assign {res_xsq, res_ysq, res_zsq} = rsq_q;
    assign res_r     = r_q;
    assign busy      = |tv_q;
    assign issue_cnt = cnt_q;
endmodule

// File: tb/tb_ray_request_scheduler.sv
// tb_ray_request_scheduler: randomized scenarios against a queue-based reference of the
// scheduler, with a behavioural calcRay (Q1.7 squares and sqrt) driving the result inputs.
module tb_ray_request_scheduler;
    localparam int N = 4, IDW = 2, IW = 8, OW = 8, SQ = 1, RL = 4;

    logic clk = 0, reset = 0, enable = 0, flush = 0;
    logic [N-1:0] req_valid = '0, req_ready;
    logic [N*IW-1:0] req_x = '0, req_y = '0, req_z = '0;
    logic [IW-1:0] ray_x, ray_y, ray_z;
    logic [OW-1:0] ray_xsq, ray_ysq, ray_zsq, ray_r;
    logic res_valid, busy;
    logic [IDW-1:0] res_id;
    logic [OW-1:0] res_xsq, res_ysq, res_zsq, res_r;
    logic [15:0] issue_cnt;

    ray_request_scheduler #(.N_REQ(N), .ID_W(IDW), .IN_W(IW), .OUT_W(OW),
        .SQ_LATENCY(SQ), .RAY_LATENCY(RL)) dut (
        .clk(clk), .reset(reset), .enable(enable), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_z(req_z),
        .ray_x(ray_x), .ray_y(ray_y), .ray_z(ray_z),
        .ray_xsq(ray_xsq), .ray_ysq(ray_ysq), .ray_zsq(ray_zsq), .ray_r(ray_r),
        .res_valid(res_valid), .res_id(res_id),
        .res_xsq(res_xsq), .res_ysq(res_ysq), .res_zsq(res_zsq), .res_r(res_r),
        .busy(busy), .issue_cnt(issue_cnt));

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] sq(input logic [IW-1:0] v);
        int a = $signed(v);
        return OW'((a * a) >>> 7);
    endfunction

    function automatic logic [OW-1:0] rt(input logic [IW-1:0] a, b, c);
        int t = (int'(sq(a)) + int'(sq(b)) + int'(sq(c))) * 128;
        int r = 0;
        while ((r + 1) * (r + 1) <= t) r++;
        return OW'(r);
    endfunction

    // behavioural calcRay: squares after SQ cycles, r after RL cycles
    logic [3*OW-1:0] sqp [SQ];
    logic [OW-1:0] rp [RL];
    always @(posedge clk) begin
        sqp[0] <= {sq(ray_x), sq(ray_y), sq(ray_z)};
        for (int i = 1; i < SQ; i++) sqp[i] <= sqp[i-1];
        rp[0] <= rt(ray_x, ray_y, ray_z);
        for (int i = 1; i < RL; i++) rp[i] <= rp[i-1];
    end
    assign {ray_xsq, ray_ysq, ray_zsq} = sqp[SQ-1];
    assign ray_r = rp[RL-1];

    typedef struct { int id; logic [OW-1:0] xs, ys, zs, r; int due; } exp_t;
    exp_t q[$];
    int glog[$];
    int oid[$];
    logic [OW-1:0] oxs[$];
    int rr_m = 0, cnt_m = 0, cyc = 0;
    int checks = 0, failures = 0;

    function automatic logic [N*IW-1:0] rnd();
        return (N*IW)'($urandom);
    endfunction

    function automatic logic [N*IW-1:0] pk(input logic [IW-1:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic tick(input logic en, fl, input logic [N-1:0] v, input logic [N*IW-1:0] x, y, z);
        logic [N-1:0] g_e;
        int sel;
        exp_t e;
        enable = en; flush = fl; req_valid = v; req_x = x; req_y = y; req_z = z;
        #1;
        g_e = '0;
        sel = -1;
        if (en && !fl)
            for (int o = 0; o < N; o++)
                if (sel < 0 && v[(rr_m + o) % N]) sel = (rr_m + o) % N;
        if (sel >= 0) g_e[sel] = 1'b1;
        checks++;
        if (req_ready !== g_e) begin
            failures++;
            $display("FAIL grant cyc=%0d got=%b exp=%b", cyc, req_ready, g_e);
        end
        if (sel >= 0) begin
            e.id = sel;
            e.xs = sq(x[sel*IW +: IW]);
            e.ys = sq(y[sel*IW +: IW]);
            e.zs = sq(z[sel*IW +: IW]);
            e.r  = rt(x[sel*IW +: IW], y[sel*IW +: IW], z[sel*IW +: IW]);
            e.due = cyc + 2 + RL;
            q.push_back(e);
            glog.push_back(sel);
            rr_m = (sel + 1) % N;
            cnt_m = (cnt_m + 1) % 65536;
        end
        if (fl) q.delete();
        @(posedge clk);
        cyc++;
        #1;
        checks++;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            if (res_valid !== 1'b1 || res_id !== e.id[IDW-1:0] || res_xsq !== e.xs ||
                res_ysq !== e.ys || res_zsq !== e.zs || res_r !== e.r) begin
                failures++;
                $display("FAIL result cyc=%0d got v=%b id=%0d sq=%h/%h/%h r=%h exp id=%0d sq=%h/%h/%h r=%h",
                    cyc, res_valid, res_id, res_xsq, res_ysq, res_zsq, res_r, e.id, e.xs, e.ys, e.zs, e.r);
            end
        end else if (res_valid !== 1'b0) begin
            failures++;
            $display("FAIL spurious_res_valid cyc=%0d got=%b exp=0", cyc, res_valid);
        end
        if (res_valid === 1'b1) begin
            oid.push_back(int'(res_id));
            oxs.push_back(res_xsq);
        end
        checks++;
        if (busy !== (q.size() > 0)) begin
            failures++;
            $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, q.size() > 0);
        end
        checks++;
        if (issue_cnt !== cnt_m[15:0]) begin
            failures++;
            $display("FAIL issue_cnt cyc=%0d got=%0d exp=%0d", cyc, issue_cnt, cnt_m);
        end
    endtask

    task automatic idle(input logic en, input int n);
        for (int i = 0; i < n; i++) tick(en, 1'b0, '0, '0, '0, '0);
    endtask

    task automatic test_reset;
        reset = 0; enable = 1; req_valid = '1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== '0 || res_valid !== 1'b0 || busy !== 1'b0 || issue_cnt !== 16'd0 ||
            ray_x !== '0 || res_id !== '0 || res_r !== '0 || res_xsq !== '0) begin
            failures++;
            $display("FAIL reset_state got rdy=%b v=%b busy=%b cnt=%0d rx=%h r=%h exp all zero",
                req_ready, res_valid, busy, issue_cnt, ray_x, res_r);
        end
        req_valid = '0; enable = 0;
        #2 reset = 1;
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_single;
        tick(1, 0, 4'b0001, pk(8'h40, 0, 0, 0), pk(8'h40, 0, 0, 0), pk(8'h40, 0, 0, 0));
        idle(1, RL + 2);
        checks++;
        if (res_id !== 2'd0 || res_xsq !== 8'h20 || res_ysq !== 8'h20 || res_zsq !== 8'h20 || res_r !== 8'h6E) begin
            failures++;
            $display("FAIL single got id=%0d sq=%h/%h/%h r=%h exp id=0 sq=20/20/20 r=6e",
                res_id, res_xsq, res_ysq, res_zsq, res_r);
        end
    endtask

    task automatic test_fairness;
        int g0, c0;
        g0 = rr_m; c0 = int'(issue_cnt);
        glog.delete();
        for (int i = 0; i < 12; i++) tick(1, 0, 4'b1111, rnd(), rnd(), rnd());
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (glog[i] != (g0 + i) % N) begin
                failures++;
                $display("FAIL fair_order i=%0d got=%0d exp=%0d", i, glog[i], (g0 + i) % N);
            end
        end
        checks++;
        if (int'(issue_cnt) != c0 + 12) begin
            failures++;
            $display("FAIL fair_count got=%0d exp=%0d", issue_cnt, c0 + 12);
        end
        idle(1, RL + 2);
    endtask

    task automatic test_alignment;
        oid.delete(); oxs.delete();
        tick(1, 0, 4'b0010, pk(0, 8'h20, 0, 0), '0, '0);
        tick(1, 0, 4'b0100, pk(0, 0, 8'h60, 0), '0, '0);
        idle(1, RL + 2);
        checks++;
        if (oid.size() != 2 || oid[0] != 1 || oid[1] != 2 || oxs[0] !== 8'h08 || oxs[1] !== 8'h48) begin
            failures++;
            $display("FAIL align got n=%0d exp n=2 ids 1,2 xsq 08,48", oid.size());
        end
    endtask

    task automatic test_flush;
        for (int i = 0; i < 3; i++) tick(1, 0, 4'b1111, rnd(), rnd(), rnd());
        idle(1, 1);
        tick(1, 1, 4'b1111, rnd(), rnd(), rnd());
        idle(1, RL + 3);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_busy got=%b exp=0", busy);
        end
        tick(1, 0, 4'b1000, rnd(), rnd(), rnd());
        idle(1, RL + 2);
    endtask

    task automatic test_enable;
        int saved;
        for (int i = 0; i < 3; i++) tick(1, 0, 4'b1111, rnd(), rnd(), rnd());
        for (int i = 0; i < RL + 4; i++) tick(0, 0, 4'b1111, rnd(), rnd(), rnd());
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL enable_busy got=%b exp=0", busy);
        end
        saved = rr_m;
        glog.delete();
        tick(1, 0, 4'b1111, rnd(), rnd(), rnd());
        checks++;
        if (glog.size() != 1 || glog[0] != saved) begin
            failures++;
            $display("FAIL enable_resume got=%0d exp=%0d", glog.size() ? glog[0] : -1, saved);
        end
        idle(1, RL + 2);
    endtask

    task automatic test_random;
        for (int i = 0; i < 300; i++)
            tick(($urandom % 8) != 0, ($urandom % 20) == 0, N'($urandom), rnd(), rnd(), rnd());
        idle(1, RL + 2);
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 5; i++) tick(1, 0, 4'b1111, rnd(), rnd(), rnd());
        #3 reset = 0;
        #1;
        checks++;
        if (req_ready !== '0 || res_valid !== 1'b0 || busy !== 1'b0 || issue_cnt !== 16'd0 ||
            ray_x !== '0 || ray_y !== '0 || res_id !== '0 || res_r !== '0) begin
            failures++;
            $display("FAIL async_reset got rdy=%b v=%b busy=%b cnt=%0d rx=%h r=%h exp all zero",
                req_ready, res_valid, busy, issue_cnt, ray_x, res_r);
        end
        q.delete(); rr_m = 0; cnt_m = 0;
        #2 reset = 1;
        idle(1, RL + 3);
        tick(1, 0, 4'b0110, rnd(), rnd(), rnd());
        idle(1, RL + 2);
    endtask

    initial begin
        test_reset;
        test_single;
        test_fairness;
        test_alignment;
        test_flush;
        test_enable;
        test_random;
        test_async_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
